// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, IR opcodes and decode helpers.
package jtag_tap_pkg;

    localparam int unsigned IR_W     = 4;
    localparam int unsigned IDCODE_W = 32;

    localparam logic [IR_W-1:0] IR_IDCODE  = 4'h1;
    localparam logic [IR_W-1:0] IR_USER    = 4'h8;
    localparam logic [IR_W-1:0] IR_BYPASS  = 4'hF;
    localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0101;

    typedef enum logic [3:0] {
        ST_EX2_DR = 4'h0,
        ST_EX1_DR = 4'h1,
        ST_SH_DR  = 4'h2,
        ST_PAU_DR = 4'h3,
        ST_SEL_IR = 4'h4,
        ST_UPD_DR = 4'h5,
        ST_CAP_DR = 4'h6,
        ST_SEL_DR = 4'h7,
        ST_EX2_IR = 4'h8,
        ST_EX1_IR = 4'h9,
        ST_SH_IR  = 4'hA,
        ST_PAU_IR = 4'hB,
        ST_RTI    = 4'hC,
        ST_UPD_IR = 4'hD,
        ST_CAP_IR = 4'hE,
        ST_TLR    = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    // Unknown opcodes fall back to the bypass register.
    function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
        case (ir)
            IR_IDCODE: return DR_IDCODE;
            IR_USER:   return DR_USER;
            default:   return DR_BYPASS;
        endcase
    endfunction

    function automatic logic is_shift(input tap_state_e s);
        return (s == ST_SH_DR) || (s == ST_SH_IR);
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Brings tck/tms/tdi into the clk domain and flags tck edges.
module jtag_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tms_s,
    output logic tdi_s,
    output logic tck_rise_c,
    output logic tck_fall_c
);

    logic [1:0] tck_q;
    logic [1:0] tms_q;
    logic [1:0] tdi_q;
    logic       tck_prev;
    logic [1:0] fill;
    logic       armed;

    // Edges are only honoured once a settled-low tck has been seen after reset,
    // so tck already high at release never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_q    <= 2'b00;
            tms_q    <= 2'b00;
            tdi_q    <= 2'b00;
            tck_prev <= 1'b0;
            fill     <= 2'b00;
            armed    <= 1'b0;
        end else begin
            tck_q    <= {tck_q[0], tck};
            tms_q    <= {tms_q[0], tms};
            tdi_q    <= {tdi_q[0], tdi};
            tck_prev <= tck_q[1];
            fill     <= {fill[0], 1'b1};
            armed    <= armed | (fill[1] & ~tck_q[1]);
        end
    end

    assign tms_s      = tms_q[1];
    assign tdi_s      = tdi_q[1];
    assign tck_rise_c = armed & tck_q[1] & ~tck_prev;
    assign tck_fall_c = armed & ~tck_q[1] & tck_prev;

endmodule

// File: rtl/jtag_tap_slave.sv
// JTAG TAP controller run entirely in the clk domain with IDCODE, USER and BYPASS data registers.
module jtag_tap_slave
    import jtag_tap_pkg::*;
#(
    parameter logic [31:0] IDCODE    = 32'h149511C3,
    parameter int unsigned USER_DR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tck,
    input  logic                 tms,
    input  logic                 tdi,
    output logic                 tdo,
    output logic                 tdo_oe,
    output logic [3:0]           tap_state,
    input  logic [USER_DR_W-1:0] user_dr_in,
    output logic [USER_DR_W-1:0] user_dr_out,
    output logic                 user_update
);

    logic tms_s;
    logic tdi_s;
    logic tck_rise_c;
    logic tck_fall_c;

    tap_state_e state;
    tap_state_e state_d;

    logic [IR_W-1:0]      ir;
    logic [IR_W-1:0]      ir_sr;
    logic [IDCODE_W-1:0]  id_sr;
    logic [USER_DR_W-1:0] user_sr;
    logic                 byp_sr;
    dr_sel_e              dr_sel;
    logic                 tdo_bit_c;

    jtag_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
        .tms_s      (tms_s),
        .tdi_s      (tdi_s),
        .tck_rise_c (tck_rise_c),
        .tck_fall_c (tck_fall_c)
    );

    assign dr_sel    = decode_ir(ir);
    assign tap_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_TLR;
        else        state <= state_d;
    end

    // TAP state transitions, evaluated only on a tck rising edge.
    always_comb begin
        state_d = state;
        if (tck_rise_c) begin
            case (state)
                ST_TLR:    state_d = tms_s ? ST_TLR    : ST_RTI;
                ST_RTI:    state_d = tms_s ? ST_SEL_DR : ST_RTI;
                ST_SEL_DR: state_d = tms_s ? ST_SEL_IR : ST_CAP_DR;
                ST_CAP_DR: state_d = tms_s ? ST_EX1_DR : ST_SH_DR;
                ST_SH_DR:  state_d = tms_s ? ST_EX1_DR : ST_SH_DR;
                ST_EX1_DR: state_d = tms_s ? ST_UPD_DR : ST_PAU_DR;
                ST_PAU_DR: state_d = tms_s ? ST_EX2_DR : ST_PAU_DR;
                ST_EX2_DR: state_d = tms_s ? ST_UPD_DR : ST_SH_DR;
                ST_UPD_DR: state_d = tms_s ? ST_SEL_DR : ST_RTI;
                ST_SEL_IR: state_d = tms_s ? ST_TLR    : ST_CAP_IR;
                ST_CAP_IR: state_d = tms_s ? ST_EX1_IR : ST_SH_IR;
                ST_SH_IR:  state_d = tms_s ? ST_EX1_IR : ST_SH_IR;
                ST_EX1_IR: state_d = tms_s ? ST_UPD_IR : ST_PAU_IR;
                ST_PAU_IR: state_d = tms_s ? ST_EX2_IR : ST_PAU_IR;
                ST_EX2_IR: state_d = tms_s ? ST_UPD_IR : ST_SH_IR;
                ST_UPD_IR: state_d = tms_s ? ST_SEL_DR : ST_RTI;
                default:   state_d = ST_TLR;
            endcase
        end
    end

    always_comb begin
        tdo_bit_c = 1'b0;
        if (state == ST_SH_IR) begin
            tdo_bit_c = ir_sr[0];
        end else if (state == ST_SH_DR) begin
            case (dr_sel)
                DR_IDCODE: tdo_bit_c = id_sr[0];
                DR_USER:   tdo_bit_c = user_sr[0];
                default:   tdo_bit_c = byp_sr;
            endcase
        end
    end

    // Capture/shift/update datapath; the shift on the Exit1 edge happens from the Shift state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir          <= IR_IDCODE;
            ir_sr       <= '0;
            id_sr       <= '0;
            user_sr     <= '0;
            byp_sr      <= 1'b0;
            user_dr_out <= '0;
            user_update <= 1'b0;
            tdo         <= 1'b0;
            tdo_oe      <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (tck_rise_c) begin
                case (state)
                    ST_CAP_IR: ir_sr <= IR_CAPTURE;
                    ST_SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
                    ST_UPD_IR: ir    <= ir_sr;
                    ST_CAP_DR: begin
                        case (dr_sel)
                            DR_IDCODE: id_sr   <= IDCODE;
                            DR_USER:   user_sr <= user_dr_in;
                            default:   byp_sr  <= 1'b0;
                        endcase
                    end
                    ST_SH_DR: begin
                        case (dr_sel)
                            DR_IDCODE: id_sr   <= {tdi_s, id_sr[IDCODE_W-1:1]};
                            DR_USER:   user_sr <= {tdi_s, user_sr[USER_DR_W-1:1]};
                            default:   byp_sr  <= tdi_s;
                        endcase
                    end
                    ST_UPD_DR: begin
                        if (dr_sel == DR_USER) begin
                            user_dr_out <= user_sr;
                            user_update <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == ST_TLR) ir <= IR_IDCODE;
            if (tck_fall_c) tdo <= tdo_bit_c;
            tdo_oe <= is_shift(state_d);
        end
    end

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Scoreboard bench for jtag_tap_slave: bit-banged tck at 5 clk per phase, expected scans queued up front.
module tb_jtag_tap_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_oe;
    logic [3:0]  tap_state;
    logic [31:0] user_dr_in;
    logic [31:0] user_dr_out;
    logic        user_update;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;
    int upd_hi  = 0;
    logic upd_prev = 1'b0;
    logic [63:0] exp_q[$];

    jtag_tap_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tck         (tck),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_oe      (tdo_oe),
        .tap_state   (tap_state),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_update (user_update)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (user_update) upd_hi++;
        if (user_update && !upd_prev) upd_cnt++;
        upd_prev <= user_update;
    end

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_cycle(input logic m, input logic d, output logic o);
        tms = m;
        tdi = d;
        wait_clk(5);
        o = tdo;
        tck = 1'b1;
        wait_clk(5);
        tck = 1'b0;
    endtask

    // From Run-Test-Idle: full DR scan back to Run-Test-Idle.
    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output logic [3:0] st, output logic oe);
        logic o;
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        wait_clk(4);
        st = tap_state;
        oe = tdo_oe;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], o);
            dout[i] = o;
        end
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
    endtask

    task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
        logic o;
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, din[i], o);
            dout[i] = o;
        end
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
    endtask

    task automatic check_idcode_scan(input string name);
        logic [63:0] dout, expv;
        logic [3:0]  st;
        logic        oe;
        exp_q.push_back(64'h0000_0000_1495_11C3);
        scan_dr(32, 64'd0, dout, st, oe);
        expv = exp_q.pop_front();
        total++;
        if (dout !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, dout, expv);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_dr_in = 32'h0;
        wait_clk(3);
        total++;
        if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_state got=%h exp=F", tap_state); end
        total++;
        if (tdo !== 1'b0 || tdo_oe !== 1'b0) begin
            bad++; $display("FAIL reset_tdo got=%b/%b exp=0/0", tdo, tdo_oe);
        end
        total++;
        if (user_dr_out !== 32'h0 || user_update !== 1'b0) begin
            bad++; $display("FAIL reset_user got=%h/%b exp=0/0", user_dr_out, user_update);
        end
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_idcode;
        logic [63:0] dout, expv;
        logic [3:0]  st;
        logic        oe, o;
        tck_cycle(1'b0, 1'b0, o);
        wait_clk(4);
        total++;
        if (tap_state !== 4'hC) begin bad++; $display("FAIL rti_state got=%h exp=C", tap_state); end
        exp_q.push_back(64'h0000_0000_1495_11C3);
        scan_dr(32, 64'd0, dout, st, oe);
        expv = exp_q.pop_front();
        total++;
        if (dout !== expv) begin bad++; $display("FAIL idcode got=%h exp=%h", dout, expv); end
        total++;
        if (st !== 4'h2 || oe !== 1'b1) begin
            bad++; $display("FAIL shift_dr_state got=%h/%b exp=2/1", st, oe);
        end
        wait_clk(5);
        total++;
        if (tdo !== 1'b0 || tdo_oe !== 1'b0 || tap_state !== 4'hC) begin
            bad++; $display("FAIL idle_outputs got=%b/%b/%h exp=0/0/C", tdo, tdo_oe, tap_state);
        end
    endtask

    task automatic test_bypass;
        logic [3:0]  irout;
        logic [63:0] dout, expv;
        logic [3:0]  st;
        logic        oe;
        int          c0;
        c0 = upd_cnt;
        exp_q.push_back(64'h5);
        scan_ir(4'hF, irout);
        expv = exp_q.pop_front();
        total++;
        if ({60'd0, irout} !== expv) begin bad++; $display("FAIL ir_capture got=%h exp=%h", irout, expv); end
        exp_q.push_back(64'h14A);
        scan_dr(9, 64'hA5, dout, st, oe);
        expv = exp_q.pop_front();
        total++;
        if (dout !== expv) begin bad++; $display("FAIL bypass got=%h exp=%h", dout, expv); end
        total++;
        if (upd_cnt !== c0) begin bad++; $display("FAIL bypass_no_update got=%0d exp=%0d", upd_cnt, c0); end
    endtask

    task automatic test_tlr_from_shift;
        logic o;
        int   c0;
        c0 = upd_cnt;
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, o);
        wait_clk(4);
        total++;
        if (tap_state !== 4'hF) begin bad++; $display("FAIL tlr_reach got=%h exp=F", tap_state); end
        total++;
        if (upd_cnt !== c0) begin bad++; $display("FAIL tlr_no_update got=%0d exp=%0d", upd_cnt, c0); end
        tck_cycle(1'b0, 1'b0, o);
        check_idcode_scan("tlr_ir_idcode");
    endtask

    task automatic test_user;
        logic [3:0]  irout;
        logic [63:0] dout, expv;
        logic [3:0]  st;
        logic        oe;
        int          c0, h0;
        user_dr_in = 32'h1234_5678;
        exp_q.push_back(64'h5);
        scan_ir(4'h8, irout);
        expv = exp_q.pop_front();
        total++;
        if ({60'd0, irout} !== expv) begin bad++; $display("FAIL user_ir_capture got=%h exp=%h", irout, expv); end
        c0 = upd_cnt;
        h0 = upd_hi;
        exp_q.push_back(64'h1234_5678);
        scan_dr(32, 64'hDEAD_BEEF, dout, st, oe);
        expv = exp_q.pop_front();
        total++;
        if (dout !== expv) begin bad++; $display("FAIL user_capture got=%h exp=%h", dout, expv); end
        total++;
        if (user_dr_out !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL user_dr_out got=%h exp=deadbeef", user_dr_out);
        end
        total++;
        if (upd_cnt - c0 !== 1 || upd_hi - h0 !== 1) begin
            bad++; $display("FAIL user_pulse got=%0d/%0d exp=1/1", upd_cnt - c0, upd_hi - h0);
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [3:0] irout;
        logic       o;
        int         c0;
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        tck_cycle(1'b0, 1'b0, o);
        scan_ir(4'h8, irout);
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, o);
        wait_clk(5);
        total++;
        if (tdo_oe !== 1'b1 || tdo !== 1'b1) begin
            bad++; $display("FAIL mid_scan_active got=%b/%b exp=1/1", tdo_oe, tdo);
        end
        c0 = upd_cnt;
        rst_n = 1'b0;
        #1;
        total++;
        if (tap_state !== 4'hF || tdo !== 1'b0 || tdo_oe !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h/%b/%b exp=F/0/0", tap_state, tdo, tdo_oe);
        end
        total++;
        if (user_dr_out !== 32'h0 || user_update !== 1'b0) begin
            bad++; $display("FAIL async_reset_user got=%h/%b exp=0/0", user_dr_out, user_update);
        end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        tck_cycle(1'b0, 1'b0, o);
        check_idcode_scan("post_reset_idcode");
        total++;
        if (upd_cnt !== c0 || user_dr_out !== 32'h0) begin
            bad++; $display("FAIL post_reset_user got=%0d/%h exp=%0d/0", upd_cnt, user_dr_out, c0);
        end
    endtask

    task automatic test_release_tck_high;
        logic o;
        rst_n = 1'b0;
        tck = 1'b1;
        tms = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        total++;
        if (tap_state !== 4'hF) begin bad++; $display("FAIL tck_high_release got=%h exp=F", tap_state); end
        tck = 1'b0;
        wait_clk(5);
        tck_cycle(1'b0, 1'b0, o);
        wait_clk(4);
        total++;
        if (tap_state !== 4'hC) begin bad++; $display("FAIL first_edge_after got=%h exp=C", tap_state); end
    endtask

    initial begin
        test_reset;
        test_idcode;
        test_bypass;
        test_tlr_from_shift;
        test_user;
        test_reset_mid_scan;
        test_release_tck_high;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
